// File: rtl/ahb_slave_if_pkg.sv
// Shared bridge definitions: AHB transfer/burst encodings, peripheral address
// windows, burst-tracker state type and small burst-decode helpers.
package ahb_slave_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  // Peripheral address windows (inclusive limits)
  localparam logic [ADDR_W-1:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [ADDR_W-1:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [ADDR_W-1:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [ADDR_W-1:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  // Beats minus one for fixed-length bursts; 0 for SINGLE and INCR
  function automatic logic [CNT_W-1:0] burst_last_beat(input logic [2:0] burst);
    case (burst)
      HB_WRAP4,  HB_INCR4:  return CNT_W'(3);
      HB_WRAP8,  HB_INCR8:  return CNT_W'(7);
      HB_WRAP16, HB_INCR16: return CNT_W'(15);
      default:              return '0;
    endcase
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    return (burst == HB_WRAP4) || (burst == HB_WRAP8) || (burst == HB_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// Next-beat address for a burst, purely combinational.
// Ports: addr (current beat address), hsize (log2 beat bytes), hburst (burst
// type used for wrap decision), next_addr_c (address the next beat must use).
module ahb_burst_addr_calc
  import ahb_slave_if_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  output logic [ADDR_W-1:0] next_addr_c
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] wrap_mask;
  logic [CNT_W:0]    beats;

  // Wrap bursts keep the bits above the beats*size boundary and increment below it
  always_comb begin
    step        = ADDR_W'(1) << hsize;
    sum         = addr + step;
    beats       = {1'b0, burst_last_beat(hburst)} + (CNT_W + 1)'(1);
    wrap_mask   = (ADDR_W'(beats) << hsize) - ADDR_W'(1);
    next_addr_c = sum;
    if (burst_is_wrap(hburst)) begin
      next_addr_c = (addr & ~wrap_mask) | (sum & wrap_mask);
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front-end of the AHB-to-APB bridge: address decode, address/data
// pipeline, read-data pass-through and burst protocol tracker.
// Ports: hclk/hresetn clock and async active-low reset; AHB address-phase
// inputs (hwrite, hreadyin, htrans, hsize, hburst, haddr, hwdata); prdata from
// APB. Outputs: valid/tempselx decode, haddr1/2 and hwdata1/2 pipeline,
// hwritereg, hrdata, beat_cnt (beats left) and burst_err (one-cycle pulse).
module ahb_slave_if
  import ahb_slave_if_pkg::*;
(
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              valid,
  output logic [ADDR_W-1:0] haddr1,
  output logic [ADDR_W-1:0] haddr2,
  output logic [DATA_W-1:0] hwdata1,
  output logic [DATA_W-1:0] hwdata2,
  output logic              hwritereg,
  output logic [SEL_W-1:0]  tempselx,
  output logic [DATA_W-1:0] hrdata,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              burst_err
);

  burst_state_e      state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [2:0]        burst_q, burst_d;
  logic              burst_err_d;
  logic [2:0]        calc_burst;
  logic [ADDR_W-1:0] calc_next;
  logic              nonseq_v;
  logic              seq_v;
  logic              start_v;

  // Peripheral select decode
  always_comb begin
    tempselx = '0;
    if (haddr >= SLV0_BASE && haddr <= SLV0_LIMIT) begin
      tempselx = 3'b001;
    end else if (haddr >= SLV1_BASE && haddr <= SLV1_LIMIT) begin
      tempselx = 3'b010;
    end else if (haddr >= SLV2_BASE && haddr <= SLV2_LIMIT) begin
      tempselx = 3'b100;
    end
  end

  always_comb begin
    valid = hreadyin && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) &&
            (tempselx != '0);
  end

  assign hrdata = prdata;

  // A NONSEQ starts a new burst from its own hburst; SEQ beats follow the stored type
  assign calc_burst = (htrans == HTRANS_NONSEQ) ? hburst : burst_q;

  ahb_burst_addr_calc u_addr_calc (
    .addr        (haddr),
    .hsize       (hsize),
    .hburst      (calc_burst),
    .next_addr_c (calc_next)
  );

  // Address/data pipeline advances only on accepted phases
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1    <= '0;
      haddr2    <= '0;
      hwdata1   <= '0;
      hwdata2   <= '0;
      hwritereg <= 1'b0;
    end else if (hreadyin) begin
      haddr1    <= haddr;
      haddr2    <= haddr1;
      hwdata1   <= hwdata;
      hwdata2   <= hwdata1;
      hwritereg <= hwrite;
    end
  end

  // Burst tracker state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      beat_cnt   <= '0;
      exp_addr_q <= '0;
      burst_q    <= '0;
      burst_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt   <= beat_cnt_d;
      exp_addr_q <= exp_addr_d;
      burst_q    <= burst_d;
      burst_err  <= burst_err_d;
    end
  end

  // Burst tracker next-state; error tracking resyncs to the received address
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt;
    exp_addr_d  = exp_addr_q;
    burst_d     = burst_q;
    burst_err_d = 1'b0;
    nonseq_v    = valid && (htrans == HTRANS_NONSEQ);
    seq_v       = valid && (htrans == HTRANS_SEQ);
    start_v     = nonseq_v && (hburst != HB_SINGLE);

    if (hreadyin) begin
      case (state_q)
        ST_IDLE: begin
          if (start_v) begin
            state_d    = ST_BURST;
            burst_d    = hburst;
            beat_cnt_d = burst_last_beat(hburst);
            exp_addr_d = calc_next;
          end else if (seq_v) begin
            burst_err_d = 1'b1;
          end
        end
        ST_BURST: begin
          if (htrans == HTRANS_BUSY) begin
            state_d = ST_BURST;
          end else if (seq_v) begin
            burst_err_d = (haddr != exp_addr_q);
            exp_addr_d  = calc_next;
            if (burst_q != HB_INCR) begin
              beat_cnt_d = beat_cnt - CNT_W'(1);
              if (beat_cnt == CNT_W'(1)) begin
                state_d = ST_IDLE;
              end
            end
          end else if (start_v) begin
            burst_d    = hburst;
            beat_cnt_d = burst_last_beat(hburst);
            exp_addr_d = calc_next;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
